// File: rtl/mem_rwtest_if.sv
// Command/status bundle between a controller and the mem_rwtest block.
//   master : drives start, mode (and inj when MEM_RWTEST_FAULT_EN is defined)
//   slave  : mem_rwtest itself; drives busy, done, fail, err_cnt, fail_addr, led
// Optional feature macro: MEM_RWTEST_FAULT_EN adds the inj fault-injection line.
interface mem_rwtest_if #(
  parameter int unsigned AW = 4
);
  logic          start;
  logic [1:0]    mode;
`ifdef MEM_RWTEST_FAULT_EN
  logic          inj;
`endif
  logic          busy;
  logic          done;
  logic          fail;
  logic [7:0]    err_cnt;
  logic [AW-1:0] fail_addr;
  logic [7:0]    led;

  modport master (
    output start,
    output mode,
`ifdef MEM_RWTEST_FAULT_EN
    output inj,
`endif
    input  busy,
    input  done,
    input  fail,
    input  err_cnt,
    input  fail_addr,
    input  led
  );

  modport slave (
    input  start,
    input  mode,
`ifdef MEM_RWTEST_FAULT_EN
    input  inj,
`endif
    output busy,
    output done,
    output fail,
    output err_cnt,
    output fail_addr,
    output led
  );
endinterface

// File: rtl/mem_rwtest.sv
// Memory read/write self-tester. Owns a 2^AW x DW synchronous single-port RAM,
// fills it with a selectable pattern, reads every word back and compares it
// against the regenerated pattern. Every FSM step is paced by a CDIV-cycle
// strobe so the sweep can be followed on the LEDs.
//
// Ports:
//   clk   - system clock
//   rst   - asynchronous reset, active-low
//   bus   - mem_rwtest_if.slave:
//             start (in)      level, accepted in IDLE or DONE
//             mode  (in, 2)   0 addr, 1 ~addr, 2 walking one, 3 Galois LFSR
//             inj   (in)      only with MEM_RWTEST_FAULT_EN: flips bit 0 of a write
//             busy/done/fail  run status
//             err_cnt (8)     mismatching words, saturating at 255
//             fail_addr (AW)  first mismatching address
//             led (8)         {fail, done, busy, 0, cur_addr[3:0]}
//
// Optional feature macro: MEM_RWTEST_FAULT_EN (fault injection on writes).
module mem_rwtest #(
  parameter int unsigned DW   = 8,
  parameter int unsigned AW   = 4,
  parameter int unsigned CDIV = 10
) (
  input  logic         clk,
  input  logic         rst,
  mem_rwtest_if.slave  bus
);

  localparam int unsigned DEPTH = 2 ** AW;
  localparam int unsigned CW    = (CDIV > 1) ? $clog2(CDIV) : 1;
  localparam int unsigned SW    = $clog2(DW);
  localparam logic [31:0] POLY32 = (DW == 32) ? 32'h8020_0003 :
                                   (DW == 16) ? 32'h0000_B400 :
                                                32'h0000_00B8;
  localparam logic [DW-1:0] POLY = POLY32[DW-1:0];

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_RD_ISSUE,
    S_RD_CMP,
    S_DONE
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [CW-1:0]   cnt;
  logic            stb;
  logic [AW-1:0]   cur_addr;
  logic            last;
  logic [1:0]      mode_q;
  logic [DW-1:0]   lfsr;
  logic [DW-1:0]   lfsr_step;
  logic [DW-1:0]   pat;
  logic [DW-1:0]   wdata;
  logic [DW-1:0]   rdata;
  logic [SW-1:0]   sh;
  logic            mismatch;
  logic [7:0]      err_cnt;
  logic [7:0]      err_nxt;
  logic [AW-1:0]   fail_addr;
  logic            busy_q;
  logic            done_q;
  logic            fail_q;

  // Decoded per-cycle actions from the FSM output process
  logic            accept;
  logic            do_wr;
  logic            do_iss;
  logic            do_cmp;
  logic            finish;

  logic [DW-1:0]   mem [DEPTH];

  // Step pacing: strobe on the last count of each CDIV-cycle window
  assign stb  = (cnt == CW'(CDIV - 1));
  assign last = (cur_addr == '1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (accept || stb) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (bus.start) state_nxt = S_WRITE;
      S_WRITE:        if (stb && last) state_nxt = S_RD_ISSUE;
      S_RD_ISSUE:     if (stb) state_nxt = S_RD_CMP;
      S_RD_CMP:       if (stb) state_nxt = last ? S_DONE : S_RD_ISSUE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: one-cycle action strobes for the datapath
  always_comb begin
    accept = 1'b0;
    do_wr  = 1'b0;
    do_iss = 1'b0;
    do_cmp = 1'b0;
    finish = 1'b0;
    case (state)
      S_IDLE, S_DONE: accept = bus.start;
      S_WRITE:        do_wr  = stb;
      S_RD_ISSUE:     do_iss = stb;
      S_RD_CMP: begin
        do_cmp = stb;
        finish = stb && last;
      end
      default: ;
    endcase
  end

  // Pattern generator; address is resized to DW, walking-one uses addr mod DW
  assign sh        = SW'(cur_addr);
  assign lfsr_step = (lfsr >> 1) ^ (lfsr[0] ? POLY : '0);

  always_comb begin
    pat = lfsr;
    case (mode_q)
      2'd0:    pat = DW'(cur_addr);
      2'd1:    pat = ~DW'(cur_addr);
      2'd2:    pat = DW'(1) << sh;
      default: pat = lfsr;
    endcase
  end

  // Write data, optionally corrupted in bit 0 to exercise the error path
  always_comb begin
    wdata = pat;
`ifdef MEM_RWTEST_FAULT_EN
    if (bus.inj) wdata[0] = ~pat[0];
`endif
  end

  assign mismatch = (rdata != pat);

  always_comb begin
    err_nxt = err_cnt;
    if (do_cmp && mismatch && (err_cnt != 8'hFF)) err_nxt = err_cnt + 8'd1;
  end

  // RAM with one-cycle registered read; contents are not reset
  always_ff @(posedge clk) begin
    if (do_wr)  mem[cur_addr] <= wdata;
    if (do_iss) rdata         <= mem[cur_addr];
  end

  // Run datapath and status registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q    <= '0;
      lfsr      <= '0;
      cur_addr  <= '0;
      err_cnt   <= '0;
      fail_addr <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
    end else if (accept) begin
      mode_q    <= bus.mode;
      lfsr      <= DW'(1);
      cur_addr  <= '0;
      err_cnt   <= '0;
      fail_addr <= '0;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      if (do_wr) begin
        cur_addr <= cur_addr + AW'(1);
        // Read phase regenerates the LFSR sequence from the same seed
        lfsr     <= last ? DW'(1) : lfsr_step;
      end
      if (do_cmp) begin
        err_cnt  <= err_nxt;
        if (mismatch && (err_cnt == 8'd0)) fail_addr <= cur_addr;
        cur_addr <= cur_addr + AW'(1);
        lfsr     <= lfsr_step;
      end
      if (finish) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
        fail_q <= (err_nxt != 8'd0);
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.fail      = fail_q;
  assign bus.err_cnt   = err_cnt;
  assign bus.fail_addr = fail_addr;
  assign bus.led       = {fail_q, done_q, busy_q, 1'b0, 4'(cur_addr)};

endmodule

// File: doc/mem_rwtest.md
Name: mem_rwtest

Overview:
Parametrised successor to the 8-bit memory read/write tester. It owns a synchronous single-port RAM of 2^AW words of DW bits. On command it writes a selectable data pattern to every address, reads each word back and compares it against the regenerated pattern. Pass, fail and error count are reported on status outputs and an 8-bit LED bus. It sits below `top` in place of the fixed-size tester; CDIV slows the sweep so it is visible on the LEDs.

Parameters:
DW, 8, data width; legal values 8, 16, 32.
AW, 4, address width; depth is 2^AW, with 2 <= AW <= 12.
CDIV, 10, clk cycles per FSM step; must be >= 1.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low (0 = reset asserted)
start  in  1  level; sampled in IDLE or DONE, starts one run
mode  in  2  pattern select, latched at start
busy  out  1  high from run start until DONE
done  out  1  high in DONE until next start or reset
fail  out  1  high in DONE if err_cnt != 0
err_cnt  out  8  number of mismatching words, saturates at 255
fail_addr  out  AW  first mismatching address; 0 if none
led  out  8  {fail, done, busy, 1'b0, cur_addr[3:0]}; cur_addr zero-extended when AW < 4

Behaviour:
- Reset (rst=0, async): state=IDLE, step counter=0, all outputs 0, led=0. RAM contents after reset are undefined.
- Step strobe:
  - The step counter counts 0..CDIV-1 and the strobe fires when it reaches CDIV-1.
  - The counter is cleared on the cycle start is accepted.
  - All FSM transitions and address advances except start acceptance happen only on a strobe.
- FSM states: IDLE, WRITE, RD_ISSUE, RD_CMP, DONE.
  - IDLE/DONE with start=1 (any clk): latch mode, clear err_cnt/fail_addr/cur_addr/done/fail, seed LFSR, set busy, go to WRITE.
  - WRITE, on each strobe: write pattern(cur_addr) to RAM[cur_addr], then increment cur_addr. At the last address, wrap cur_addr to 0, reseed LFSR and go to RD_ISSUE.
  - RD_ISSUE, on strobe: present cur_addr to RAM; go to RD_CMP. RAM read latency is 1 clk.
  - RD_CMP, on strobe: compare registered read data with pattern(cur_addr).
    - On mismatch, increment err_cnt (saturating); if this is the first error, capture fail_addr=cur_addr.
    - Then increment cur_addr and go to RD_ISSUE. At the last address go to DONE, which clears busy, sets done, and sets fail=(err_cnt_next!=0).
- start is ignored while busy. Holding start high in DONE restarts immediately.
- Run length: done rises exactly CDIV*(3*2^AW) clk after the start-accept cycle.
- Patterns are computed at width DW; the address is zero-extended or truncated to DW.
  - 0: addr
  - 1: ~addr
  - 2: 1 << (addr mod DW)
  - 3: Galois LFSR, seed 1, advanced once per WRITE or RD_CMP step. Polynomial masks: DW=8 0xB8, DW=16 0xB400, DW=32 0x80200003.
- Reset mid-run aborts the run: all outputs return to reset values and the next start performs a full run.

Optional Feature:
MEM_RWTEST_FAULT_EN
- Defined: adds input port `inj` (1 bit). During a WRITE step with inj=1, bit 0 of the written word is inverted. This is used to prove the error path works.
- Undefined: the port does not exist and data is always written unmodified.

Test Plan:
- Reset: rst=0 for 1 ns, then rst=1 -> led=0, busy=0, done=0, err_cnt=0, with no clk edge required.
- DW=8, AW=4, CDIV=10, mode=0, start pulsed 1 clk -> busy=1 next clk; done=1 and fail=0 exactly 480 clk later; err_cnt=0; led=8'b0100_0000 after done.
- Modes 1, 2 and 3 each run as in scenario 2 -> fail=0 for every mode. A probe of RAM at address 5 reads 0xFA, 0x20 and the 5th LFSR state respectively.
- With MEM_RWTEST_FAULT_EN, inj held high during the address-3 and address-9 write steps -> fail=1, err_cnt=2, fail_addr=3, led[7]=1.
- Mid-run rst: drop rst in the RD_CMP step of address 7 -> outputs return to 0 immediately. A new start then gives a clean pass, done after 480 clk.
- start held high continuously -> back-to-back runs with done high for exactly 1 clk between runs. start asserted while busy has no effect on timing.
